// File: rtl/ahbl_apb_pkg.sv
// Shared encodings, limits and FSM state type for the AHB-Lite to APB3 bridge.
package ahbl_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_MAX = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_apb_timeout.sv
// Wait-state counter for the APB ACCESS phase; expired_o flags the last allowed
// PREADY-low cycle. Tied off entirely when TIMEOUT is 0.
module ahbl_apb_timeout #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_i, clr_i, inc_i};
        assign expired_o     = 1'b0;
    end else begin : g_cnt
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

        logic [CW-1:0] count_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else if (clr_i) begin
                count_q <= '0;
            end else if (inc_i) begin
                count_q <= count_q + 1'b1;
            end
        end

        assign expired_o = (count_q == LAST);
    end

endmodule

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB SETUP/ACCESS per accepted AHB
// transfer, data phase stretched with HREADYOUT, errors returned as two-cycle ERROR.
module ahbl_to_apb_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int unsigned APB_AWIDTH = 16,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [APB_AWIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_e                state_q;
    logic [31:0]           hrdata_q;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [APB_AWIDTH-1:0] paddr_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [31:0]           pwdata_q;

    logic accept;
    logic tmo_expired;

    assign accept = HSEL & HREADYIN & is_active(HTRANS);

    ahbl_apb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (HCLK),
        .rst_i     (HRESET),
        .clr_i     (state_q == ST_SETUP),
        .inc_i     ((state_q == ST_ACCESS) && !PREADY),
        .expired_o (tmo_expired)
    );

    if (APB_AWIDTH < 32) begin : g_unused_haddr
        logic unused_haddr;
        assign unused_haddr = ^HADDR[31:APB_AWIDTH];
    end

    // NOTE: every output is a flop cleared by the async reset, so a reset mid-transfer
    // drops PSEL/PENABLE at once and there is no combinational PREADY->HREADYOUT path.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            case (state_q)
                ST_WDATA: begin
                    pwdata_q <= HWDATA;
                    psel_q   <= 1'b1;
                    state_q  <= ST_SETUP;
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY && !PSLVERR) begin
                        if (!pwrite_q) begin
                            hrdata_q <= PRDATA;
                        end
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                        state_q     <= ST_DONE;
                    end else if (PREADY || tmo_expired) begin
                        // Slave error or timeout abort: first ERROR cycle keeps HREADYOUT low.
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        hresp_q   <= HRESP_ERROR;
                        state_q   <= ST_ERR1;
                    end
                end
                ST_ERR1: begin
                    hreadyout_q <= 1'b1;
                    state_q     <= ST_ERR2;
                end
                default: begin
                    // IDLE, DONE and ERR2 are the only states that can take a new address phase.
                    if (accept) begin
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                        if (HSIZE > HSIZE_MAX) begin
                            hresp_q <= HRESP_ERROR;
                            state_q <= ST_ERR1;
                        end else begin
                            paddr_q  <= HADDR[APB_AWIDTH-1:0];
                            pwrite_q <= HWRITE;
                            if (HWRITE) begin
                                state_q <= ST_WDATA;
                            end else begin
                                psel_q  <= 1'b1;
                                state_q <= ST_SETUP;
                            end
                        end
                    end else begin
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// Self-checking bench for ahbl_to_apb_bridge: directed scenarios plus random transfers
// checked cycle by cycle against a latency/response model derived from transfer rules.
module tb_ahbl_to_apb_bridge;

    localparam int TMO = 4;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_hrdata = '0;

    // Single-slave system: bus-level HREADY is this slave's HREADYOUT.
    assign hreadyin = hreadyout;

    ahbl_to_apb_bridge #(
        .APB_AWIDTH (16),
        .TIMEOUT    (TMO)
    ) dut (
        .HCLK      (hclk),
        .HRESET    (hreset),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HWDATA    (hwdata),
        .HREADYIN  (hreadyin),
        .HRDATA    (hrdata),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .PADDR     (paddr),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    always #5 hclk = ~hclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle or BUSY cycle (optionally selected): zero-wait OKAY, no APB activity.
    task automatic idle(input logic sel, input logic [1:0] tr);
        hsel   = sel;
        htrans = tr;
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 7));
        pready = 1'b0;
        @(negedge hclk);
        check("idle_hreadyout", {31'b0, hreadyout}, 32'd1);
        check("idle_hresp", {31'b0, hresp}, 32'd0);
        check("idle_psel", {31'b0, psel}, 32'd0);
        check("idle_hrdata", hrdata, exp_hrdata);
    endtask

    // One transfer, address phase driven at the current negedge. Returns at the negedge of
    // its final data-phase cycle so the next call issues a back-to-back address phase there.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int waits, input logic slverr,
                        input logic [31:0] rdata);
        int   s;
        int   nacc;
        int   fin;
        logic legal;
        logic tmo;
        logic err;
        logic in_psel;
        logic in_pen;
        legal = (size <= 3'd2);
        s     = wr ? 2 : 1;
        tmo   = legal && (waits >= TMO);
        nacc  = tmo ? TMO : waits + 1;
        if (!legal) begin
            err = 1'b1;
            fin = 2;
        end else begin
            err = tmo || slverr;
            fin = s + 1 + nacc + (err ? 1 : 0);
        end

        hsel   = 1'b1;
        htrans = $urandom_range(0, 1) ? T_NONSEQ : T_SEQ;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        pready = 1'b0;
        @(negedge hclk);

        for (int c = 1; c <= fin; c++) begin
            in_psel = legal && (c >= s) && (c < s + 1 + nacc);
            in_pen  = legal && (c >= s + 1) && (c < s + 1 + nacc);
            if (c == fin && legal && !err && !wr) begin
                exp_hrdata = rdata;
            end
            check("hreadyout", {31'b0, hreadyout}, {31'b0, c == fin});
            check("hresp", {31'b0, hresp}, {31'b0, err && (c >= fin - 1)});
            check("psel", {31'b0, psel}, {31'b0, in_psel});
            check("penable", {31'b0, penable}, {31'b0, in_pen});
            check("hrdata", hrdata, exp_hrdata);
            if (in_psel) begin
                check("paddr", {16'b0, paddr}, {16'b0, addr[15:0]});
                check("pwrite", {31'b0, pwrite}, {31'b0, wr});
                if (wr) begin
                    check("pwdata", pwdata, wdata);
                end
            end

            if (c == 1) begin
                hsel   = 1'b0;
                htrans = T_IDLE;
                hwdata = wdata;
            end else begin
                hwdata = $urandom;
            end
            pready  = in_pen && !tmo && (c == s + 1 + waits);
            pslverr = slverr;
            prdata  = pready ? rdata : $urandom;
            if (c < fin) begin
                @(negedge hclk);
            end
        end
        pready = 1'b0;
    endtask

    initial begin
        hreset  = 1'b1;
        hsel    = 1'b0;
        haddr   = '0;
        htrans  = T_IDLE;
        hwrite  = 1'b0;
        hsize   = 3'd2;
        hwdata  = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        #1;
        check("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
        check("rst_hresp", {31'b0, hresp}, 32'd0);
        check("rst_psel", {31'b0, psel}, 32'd0);
        check("rst_penable", {31'b0, penable}, 32'd0);
        check("rst_pwrite", {31'b0, pwrite}, 32'd0);
        check("rst_paddr", {16'b0, paddr}, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        idle(1'b0, T_IDLE);

        // Zero-wait read, then zero-wait write (HRDATA must keep the read value).
        xfer(1'b0, 32'h0000_0010, 3'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        idle(1'b1, T_IDLE);
        xfer(1'b1, 32'h0000_0004, 3'd2, 32'h0000_00A5, 0, 1'b0, 32'h1234_5678);
        idle(1'b1, T_BUSY);

        // Read with three PREADY-low cycles.
        xfer(1'b0, 32'h0001_ABCD, 3'd1, 32'h0, 3, 1'b0, 32'h5A5A_0001);
        idle(1'b0, T_NONSEQ);

        // Slave error on a write, with a read issued back-to-back in ERR2.
        xfer(1'b1, 32'h0000_0020, 3'd0, 32'hDEAD_BEEF, 0, 1'b1, 32'h0);
        xfer(1'b0, 32'h0000_0024, 3'd2, 32'h0, 0, 1'b0, 32'h0BAD_C0DE);

        // Timeout with PREADY held low, then an illegal size, back-to-back.
        xfer(1'b0, 32'h0000_0030, 3'd2, 32'h0, 10, 1'b0, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h0000_0034, 3'd3, 32'h1111_2222, 0, 1'b0, 32'h0);
        idle(1'b0, T_IDLE);

        // Asynchronous reset during ACCESS.
        hsel   = 1'b1;
        htrans = T_NONSEQ;
        haddr  = 32'h0000_0040;
        hwrite = 1'b0;
        hsize  = 3'd2;
        @(negedge hclk);
        hsel   = 1'b0;
        htrans = T_IDLE;
        @(negedge hclk);
        check("pre_rst_penable", {31'b0, penable}, 32'd1);
        #2;
        hreset = 1'b1;
        #1;
        exp_hrdata = '0;
        check("mid_rst_psel", {31'b0, psel}, 32'd0);
        check("mid_rst_penable", {31'b0, penable}, 32'd0);
        check("mid_rst_hresp", {31'b0, hresp}, 32'd0);
        check("mid_rst_hreadyout", {31'b0, hreadyout}, 32'd1);
        check("mid_rst_hrdata", hrdata, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        xfer(1'b0, 32'h0000_0044, 3'd2, 32'h0, 0, 1'b0, 32'h7777_8888);

        // Random mix of reads, writes, waits, errors, illegal sizes and idle gaps.
        for (int n = 0; n < 120; n++) begin
            logic       wr;
            logic [2:0] sz;
            int         w;
            if ($urandom_range(0, 2) == 0) begin
                idle(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? T_BUSY : T_IDLE);
            end
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            w  = $urandom_range(0, 5);
            xfer(wr, $urandom, sz, $urandom, w, ($urandom_range(0, 4) == 0), $urandom);
        end
        idle(1'b0, T_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
